// File: rtl/exi_cmd_ctrl_if.sv
// SPI-side byte stream and buffer-RAM port bundle for the EXI command sequencer.
// Handshake: frame_start, frame_end and rx_valid are single-cycle pulses with no
// back-pressure (no ready). rx_byte is meaningful only while rx_valid is high.
// ram_we/ram_re are single-cycle strobes qualified by ram_addr/ram_wdata, and
// ram_rdata answers a ram_re strobe on the following cycle.
interface exi_cmd_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic              frame_start;
    logic              frame_end;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_byte;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [7:0]        ram_rdata;

    // Environment side: deserializer pulses out, RAM read data out.
    modport master (
        output frame_start, frame_end, rx_valid, rx_byte, ram_rdata,
        input  tx_byte, ram_addr, ram_wdata, ram_we, ram_re
    );

    // Sequencer side.
    modport slave (
        input  frame_start, frame_end, rx_valid, rx_byte, ram_rdata,
        output tx_byte, ram_addr, ram_wdata, ram_we, ram_re
    );
endinterface

// File: rtl/exi_cmd_ctrl.sv
// EXI command sequencer: decodes CS-framed command/address/data bytes, drives
// buffer-RAM reads and writes with address auto-increment and supplies the
// next MISO byte. All outputs are registered.
module exi_cmd_ctrl #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] DEV_ID    = 8'hA5,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic           clk,
    input  logic           rst,
    exi_cmd_ctrl_if.slave  bus,
    output logic           busy,
    output logic [7:0]     frame_cnt,
    output logic [2:0]     dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_WR   = 3'd3,
        S_RD   = 3'd4,
        S_TAIL = 3'd5
    } state_t;

    state_t            state, state_nxt, st_eff;
    logic              is_read, is_read_nxt;
    logic              got_byte, got_nxt;
    logic              err_short, err_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [7:0]        tx_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        wdata_nxt;
    logic              we_nxt, re_nxt;
    logic [7:0]        cnt_nxt;
    // Prefetch pipeline: rd_p1 marks the cycle ram_re is high, rd_p2 the
    // cycle ram_rdata is valid and gets captured into tx_byte.
    logic              rd_p1, rd_p1_nxt;
    logic              rd_p2, rd_p2_nxt;
    logic              abort;

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // State and output registers; reset cancels any pending strobe or prefetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            is_read       <= 1'b0;
            got_byte      <= 1'b0;
            err_short     <= 1'b0;
            ptr           <= '0;
            frame_cnt     <= 8'd0;
            rd_p1         <= 1'b0;
            rd_p2         <= 1'b0;
            bus.tx_byte   <= IDLE_BYTE;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= 8'd0;
            bus.ram_we    <= 1'b0;
            bus.ram_re    <= 1'b0;
        end else begin
            state         <= state_nxt;
            is_read       <= is_read_nxt;
            got_byte      <= got_nxt;
            err_short     <= err_nxt;
            ptr           <= ptr_nxt;
            frame_cnt     <= cnt_nxt;
            rd_p1         <= rd_p1_nxt;
            rd_p2         <= rd_p2_nxt;
            bus.tx_byte   <= tx_nxt;
            bus.ram_addr  <= addr_nxt;
            bus.ram_wdata <= wdata_nxt;
            bus.ram_we    <= we_nxt;
            bus.ram_re    <= re_nxt;
        end
    end

    // Next state and outputs: the received byte is processed first, then a
    // frame end (or a restart via frame_start) closes the frame.
    always_comb begin
        state_nxt   = state;
        st_eff      = state;
        is_read_nxt = is_read;
        got_nxt     = got_byte;
        err_nxt     = err_short;
        ptr_nxt     = ptr;
        cnt_nxt     = frame_cnt;
        tx_nxt      = bus.tx_byte;
        addr_nxt    = bus.ram_addr;
        wdata_nxt   = bus.ram_wdata;
        we_nxt      = 1'b0;
        re_nxt      = 1'b0;
        rd_p1_nxt   = 1'b0;
        rd_p2_nxt   = rd_p1;
        abort       = (bus.frame_end || bus.frame_start) && (state != S_IDLE);

        if (bus.rx_valid && state != S_IDLE) begin
            got_nxt = 1'b1;
            case (state)
                S_CMD: begin
                    case (bus.rx_byte[7:6])
                        2'b00: begin
                            tx_nxt = DEV_ID;
                            st_eff = S_TAIL;
                        end
                        2'b11: begin
                            tx_nxt  = {err_short, 7'b0};
                            err_nxt = 1'b0;
                            st_eff  = S_TAIL;
                        end
                        default: begin
                            is_read_nxt = (bus.rx_byte[7:6] == 2'b01);
                            st_eff      = S_ADDR;
                        end
                    endcase
                end
                S_ADDR: begin
                    ptr_nxt = bus.rx_byte[ADDR_W-1:0];
                    if (is_read) begin
                        re_nxt    = 1'b1;
                        addr_nxt  = bus.rx_byte[ADDR_W-1:0];
                        rd_p1_nxt = 1'b1;
                        st_eff    = S_RD;
                    end else begin
                        st_eff = S_WR;
                    end
                end
                S_WR: begin
                    we_nxt    = 1'b1;
                    addr_nxt  = ptr;
                    wdata_nxt = bus.rx_byte;
                    ptr_nxt   = ptr + 1'b1;
                end
                S_RD: begin
                    re_nxt    = 1'b1;
                    addr_nxt  = ptr;
                    rd_p1_nxt = 1'b1;
                end
                default: ;
            endcase
        end

        // Prefetched data lands in tx_byte and the pointer moves on.
        if (rd_p2 && !abort) begin
            tx_nxt  = bus.ram_rdata;
            ptr_nxt = ptr + 1'b1;
        end

        state_nxt = st_eff;

        if (abort) begin
            // Any prefetch still in flight is dropped; a write already
            // registered completes on its own.
            tx_nxt    = IDLE_BYTE;
            rd_p1_nxt = 1'b0;
            rd_p2_nxt = 1'b0;
            got_nxt   = 1'b0;
            if ((st_eff == S_CMD || st_eff == S_ADDR) && got_nxt == 1'b0 && (got_byte || bus.rx_valid)) begin
                err_nxt = 1'b1;
            end else begin
                cnt_nxt = frame_cnt + 8'd1;
            end
            state_nxt = bus.frame_start ? S_CMD : S_IDLE;
        end else if (state == S_IDLE) begin
            if (bus.frame_end) begin
                tx_nxt = IDLE_BYTE;
            end
            if (bus.frame_start) begin
                state_nxt = S_CMD;
                got_nxt   = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exi_cmd_ctrl.sv
// Self-checking bench for exi_cmd_ctrl: table of directed frames, hand-written
// multi-cycle corner cases, and random frames scored against a frame-level model.
module tb_exi_cmd_ctrl;

    localparam logic [7:0] DEV_ID    = 8'hA5;
    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    typedef logic [7:0] bytes_t [6];

    typedef struct {
        int          n;
        bytes_t      b;
        bytes_t      tx;
        logic [7:0]  cnt;
        int          nwe;
        logic [15:0] wfirst;
        logic [15:0] wlast;
        int          nre;
        logic [7:0]  rfirst;
        logic [7:0]  rlast;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [7:0] frame_cnt;
    logic [2:0] dbg_state;

    exi_cmd_ctrl_if #(.ADDR_W(8)) bus ();

    exi_cmd_ctrl #(.ADDR_W(8), .DEV_ID(DEV_ID), .IDLE_BYTE(IDLE_BYTE)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .dbg_state (dbg_state)
    );

    // Clock and global time limit.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Buffer RAM with one-cycle read latency.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            bus.ram_rdata <= 8'h00;
        end else begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    // Strobe monitor.
    logic [15:0] act_wr_q [$];
    logic [7:0]  act_rd_q [$];
    int          clash_cnt = 0;
    always @(posedge clk) begin
        if (bus.ram_we) act_wr_q.push_back({bus.ram_addr, bus.ram_wdata});
        if (bus.ram_re) act_rd_q.push_back(bus.ram_addr);
        if (bus.ram_we && bus.ram_re) clash_cnt++;
    end

    // Scoreboard.
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Frame-level reference model.
    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_cnt = 8'd0;
    logic        ref_err = 1'b0;
    logic [15:0] exp_q [$];
    logic [7:0]  exp_rd_q [$];
    bytes_t      exp_tx;

    function automatic void ref_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_cnt = 8'd0;
        ref_err = 1'b0;
    endfunction

    function automatic void ref_frame(input int n, input bytes_t b);
        logic [7:0] a;
        logic [7:0] st;
        exp_q.delete();
        exp_rd_q.delete();
        for (int i = 0; i < 6; i++) exp_tx[i] = IDLE_BYTE;
        if (n == 0) begin
            ref_cnt = ref_cnt + 8'd1;
            return;
        end
        case (b[0][7:6])
            2'b00: begin
                for (int i = 0; i < n; i++) exp_tx[i] = DEV_ID;
                ref_cnt = ref_cnt + 8'd1;
            end
            2'b11: begin
                st = {ref_err, 7'b0};
                for (int i = 0; i < n; i++) exp_tx[i] = st;
                ref_err = 1'b0;
                ref_cnt = ref_cnt + 8'd1;
            end
            default: begin
                if (n == 1) begin
                    ref_err = 1'b1;
                end else begin
                    a = b[1];
                    if (b[0][7:6] == 2'b10) begin
                        for (int i = 2; i < n; i++) begin
                            exp_q.push_back({8'(a + 8'(i - 2)), b[i]});
                            ref_mem[8'(a + 8'(i - 2))] = b[i];
                        end
                    end else begin
                        for (int i = 1; i < n; i++) begin
                            exp_rd_q.push_back(8'(a + 8'(i - 1)));
                            exp_tx[i] = ref_mem[8'(a + 8'(i - 1))];
                        end
                    end
                    ref_cnt = ref_cnt + 8'd1;
                end
            end
        endcase
    endfunction

    // Driver tasks; inputs change and outputs are sampled on the falling edge.
    bytes_t act_tx;

    task automatic pulse_start();
        @(negedge clk) bus.frame_start = 1'b1;
        @(negedge clk) bus.frame_start = 1'b0;
    endtask

    task automatic pulse_end();
        @(negedge clk) bus.frame_end = 1'b1;
        @(negedge clk) bus.frame_end = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic [7:0] tx);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = v;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        tx = bus.tx_byte;
    endtask

    task automatic run_frame(input int n, input bytes_t b);
        act_wr_q.delete();
        act_rd_q.delete();
        pulse_start();
        for (int i = 0; i < n; i++) send_byte(b[i], act_tx[i]);
        pulse_end();
    endtask

    task automatic chk_queues(input string nm);
        chk({nm, " wr count"}, act_wr_q.size(), exp_q.size());
        chk({nm, " rd count"}, act_rd_q.size(), exp_rd_q.size());
        for (int i = 0; i < exp_q.size() && i < act_wr_q.size(); i++)
            chk({nm, " wr entry"}, act_wr_q[i], exp_q[i]);
        for (int i = 0; i < exp_rd_q.size() && i < act_rd_q.size(); i++)
            chk({nm, " rd addr"}, act_rd_q[i], exp_rd_q[i]);
    endtask

    vec_t  vec [12];
    bytes_t bb;
    logic [7:0] t;

    initial begin
        vec[0]  = '{6, '{8'h80,8'h10,8'hAA,8'hBB,8'hCC,8'h44}, '{8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF},
                    8'd1, 4, 16'h10AA, 16'h1344, 0, 8'h00, 8'h00};
        vec[1]  = '{5, '{8'h40,8'h10,8'h00,8'h00,8'h00,8'h00}, '{8'hFF,8'hAA,8'hBB,8'hCC,8'h44,8'hFF},
                    8'd2, 0, 16'h0, 16'h0, 4, 8'h10, 8'h13};
        vec[2]  = '{5, '{8'h80,8'h10,8'h11,8'h22,8'h33,8'h00}, '{8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF},
                    8'd3, 3, 16'h1011, 16'h1233, 0, 8'h00, 8'h00};
        vec[3]  = '{4, '{8'h80,8'hFF,8'h5A,8'hC3,8'h00,8'h00}, '{8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF},
                    8'd4, 2, 16'hFF5A, 16'h00C3, 0, 8'h00, 8'h00};
        vec[4]  = '{1, '{8'h80,8'h00,8'h00,8'h00,8'h00,8'h00}, '{8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF},
                    8'd4, 0, 16'h0, 16'h0, 0, 8'h00, 8'h00};
        vec[5]  = '{1, '{8'hC0,8'h00,8'h00,8'h00,8'h00,8'h00}, '{8'h80,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF},
                    8'd5, 0, 16'h0, 16'h0, 0, 8'h00, 8'h00};
        vec[6]  = '{1, '{8'hC0,8'h00,8'h00,8'h00,8'h00,8'h00}, '{8'h00,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF},
                    8'd6, 0, 16'h0, 16'h0, 0, 8'h00, 8'h00};
        vec[7]  = '{2, '{8'h00,8'h37,8'h00,8'h00,8'h00,8'h00}, '{8'hA5,8'hA5,8'hFF,8'hFF,8'hFF,8'hFF},
                    8'd7, 0, 16'h0, 16'h0, 0, 8'h00, 8'h00};
        vec[8]  = '{0, '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, '{8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF},
                    8'd8, 0, 16'h0, 16'h0, 0, 8'h00, 8'h00};
        vec[9]  = '{3, '{8'h47,8'h11,8'h00,8'h00,8'h00,8'h00}, '{8'hFF,8'h22,8'h33,8'hFF,8'hFF,8'hFF},
                    8'd9, 0, 16'h0, 16'h0, 2, 8'h11, 8'h12};
        vec[10] = '{1, '{8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00}, '{8'h00,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF},
                    8'd10, 0, 16'h0, 16'h0, 0, 8'h00, 8'h00};
        vec[11] = '{1, '{8'h47,8'h00,8'h00,8'h00,8'h00,8'h00}, '{8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF},
                    8'd10, 0, 16'h0, 16'h0, 0, 8'h00, 8'h00};

        // Reset.
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.rx_valid    = 1'b0;
        bus.rx_byte     = 8'h00;
        ref_reset();
        repeat (3) @(negedge clk);
        chk("reset tx_byte", bus.tx_byte, IDLE_BYTE);
        chk("reset ram_addr", bus.ram_addr, 8'h00);
        chk("reset ram_wdata", bus.ram_wdata, 8'h00);
        chk("reset strobes", {bus.ram_we, bus.ram_re}, 2'b00);
        chk("reset frame_cnt", frame_cnt, 8'd0);
        chk("reset busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int k = 0; k < 12; k++) begin
            run_frame(vec[k].n, vec[k].b);
            ref_frame(vec[k].n, vec[k].b);
            for (int i = 0; i < vec[k].n; i++) chk("tbl tx_byte", act_tx[i], vec[k].tx[i]);
            chk("tbl frame_cnt", frame_cnt, vec[k].cnt);
            chk("tbl tx after end", bus.tx_byte, IDLE_BYTE);
            chk("tbl busy after end", busy, 1'b0);
            chk("tbl wr count", act_wr_q.size(), vec[k].nwe);
            chk("tbl rd count", act_rd_q.size(), vec[k].nre);
            if (vec[k].nwe > 0 && act_wr_q.size() > 0) begin
                chk("tbl wr first", act_wr_q[0], vec[k].wfirst);
                chk("tbl wr last", act_wr_q[act_wr_q.size()-1], vec[k].wlast);
            end
            if (vec[k].nre > 0 && act_rd_q.size() > 0) begin
                chk("tbl rd first", act_rd_q[0], vec[k].rfirst);
                chk("tbl rd last", act_rd_q[act_rd_q.size()-1], vec[k].rlast);
            end
        end

        // Read latency: ram_re one cycle after the address byte, tx_byte two.
        act_wr_q.delete();
        act_rd_q.delete();
        pulse_start();
        send_byte(8'h40, t);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h10;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("lat ram_re", {bus.ram_re, bus.ram_addr}, {1'b1, 8'h10});
        @(negedge clk);
        chk("lat tx not early", bus.tx_byte, IDLE_BYTE);
        @(negedge clk);
        chk("lat tx at +2", bus.tx_byte, ref_mem[8'h10]);
        pulse_end();
        bb = '{8'h40, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        ref_frame(2, bb);
        chk("lat frame_cnt", frame_cnt, ref_cnt);

        // Read prefetch dropped by frame_end right after the address byte.
        act_wr_q.delete();
        act_rd_q.delete();
        pulse_start();
        send_byte(8'h40, t);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h12;
        @(negedge clk);
        bus.rx_valid  = 1'b0;
        bus.frame_end = 1'b1;
        @(negedge clk);
        bus.frame_end = 1'b0;
        repeat (3) @(negedge clk);
        chk("discard tx", bus.tx_byte, IDLE_BYTE);
        bb = '{8'h40, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
        ref_frame(2, bb);
        chk_queues("discard");
        chk("discard frame_cnt", frame_cnt, ref_cnt);

        // rx_valid coincident with frame_end in WR: write still lands.
        act_wr_q.delete();
        act_rd_q.delete();
        pulse_start();
        send_byte(8'h80, t);
        send_byte(8'h20, t);
        @(negedge clk);
        bus.rx_valid  = 1'b1;
        bus.rx_byte   = 8'h55;
        bus.frame_end = 1'b1;
        @(negedge clk);
        bus.rx_valid  = 1'b0;
        bus.frame_end = 1'b0;
        repeat (2) @(negedge clk);
        bb = '{8'h80, 8'h20, 8'h55, 8'h00, 8'h00, 8'h00};
        ref_frame(3, bb);
        chk_queues("collide");
        chk("collide busy", busy, 1'b0);
        chk("collide frame_cnt", frame_cnt, ref_cnt);

        // frame_start while open: aborted frame counted, new frame begins.
        act_wr_q.delete();
        act_rd_q.delete();
        pulse_start();
        send_byte(8'h80, t);
        send_byte(8'h40, t);
        pulse_start();
        @(negedge clk);
        chk("restart busy", busy, 1'b1);
        bb = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        ref_frame(2, bb);
        chk("restart frame_cnt", frame_cnt, ref_cnt);
        send_byte(8'h00, t);
        chk("restart id", t, DEV_ID);
        pulse_end();
        bb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ref_frame(1, bb);
        chk("restart cnt end", frame_cnt, ref_cnt);

        // rx_valid while idle does nothing.
        act_wr_q.delete();
        act_rd_q.delete();
        send_byte(8'h80, t);
        send_byte(8'h10, t);
        chk("idle no strobes", act_wr_q.size() + act_rd_q.size(), 0);
        chk("idle busy", busy, 1'b0);

        // Random frames against the model.
        for (int k = 0; k < 30; k++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int i = 0; i < 6; i++) bb[i] = 8'($urandom_range(0, 255));
            bb[0][7:6] = 2'($urandom_range(0, 3));
            run_frame(n, bb);
            ref_frame(n, bb);
            for (int i = 0; i < n; i++) chk("rnd tx_byte", act_tx[i], exp_tx[i]);
            chk_queues("rnd");
            chk("rnd frame_cnt", frame_cnt, ref_cnt);
            chk("rnd tx after end", bus.tx_byte, IDLE_BYTE);
        end
        bb = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(1, bb);
        ref_frame(1, bb);
        chk("rnd final status", act_tx[0], exp_tx[0]);

        // Reset during the WR data phase cancels the pending write.
        act_wr_q.delete();
        act_rd_q.delete();
        pulse_start();
        send_byte(8'h80, t);
        send_byte(8'h30, t);
        send_byte(8'h77, t);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h66;
        rst          = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("rst tx_byte", bus.tx_byte, IDLE_BYTE);
        chk("rst ram_addr", bus.ram_addr, 8'h00);
        chk("rst ram_wdata", bus.ram_wdata, 8'h00);
        chk("rst strobes", {bus.ram_we, bus.ram_re}, 2'b00);
        chk("rst frame_cnt", frame_cnt, 8'd0);
        chk("rst busy", busy, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst write count", act_wr_q.size(), 1);
        if (act_wr_q.size() > 0) chk("rst write entry", act_wr_q[0], 16'h3077);
        ref_reset();

        chk("no we/re overlap", clash_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
